hdmi_layer_arbiter: RTL and testbench
=====================================

# hdmi_layer_arbiter

Arbitrates pixel fetch for the two image regions of the 720p HDMI output path. It takes the per-pixel region-active strobes and frame sync from the timing generator and drives read addresses for two image buffers. It returns the winning RGB pixel on the timing generator's `img_r/g/b` inputs exactly one cycle later. Layer enables and priority are CPU-programmed, shadowed, and take effect only at frame boundaries.

## Interface
- `IMG0_PIXELS`, 65536: pixel count of buffer 0 (W×H, e.g. 256×256).
- `IMG1_PIXELS`, 65536: pixel count of buffer 1.
- `ADDR_W`, 16: buffer address width; must satisfy 2^ADDR_W ≥ max(IMG0_PIXELS, IMG1_PIXELS).

Ports:
- `video_clk`  in  1  pixel clock; only clock of the block.
- `rst`  in  1  asynchronous, active-high reset.
- `vs`  in  1  field sync from timing generator, active high.
- `region_0_active`  in  1  current pixel lies in region 0.
- `region_1_active`  in  1  current pixel lies in region 1.
- `cfg_en0`, `cfg_en1`  in  1 each  layer enables (CPU domain, quasi-static).
- `cfg_prio1`  in  1  1 = region 1 wins overlap, 0 = region 0 wins.
- `ram0_rd`, `ram1_rd`  out  1 each  read strobes.
- `ram0_addr`, `ram1_addr`  out  ADDR_W each  read addresses.
- `ram0_rdata`, `ram1_rdata`  in  24 each  {R,G,B}; synchronous RAM, 1-cycle latency.
- `img_r`, `img_g`, `img_b`  out  8 each  selected pixel.
- `frame_start`  out  1  one-cycle pulse on each `vs` rising edge.
- `overrun`  out  1  sticky: a region requested more pixels than its buffer holds this frame.

## Operation
- Two-state FSM.
  - `S_IDLE`: entered on reset. No reads are issued and `img` is 0.
  - `S_RUN`: entered on the first `vs` rising edge (registered `vs` compared with its previous value). The FSM stays in `S_RUN` until reset.
- On each `vs` rising edge (all states):
  - Pulse `frame_start`.
  - Clear both address counters to 0.
  - Clear `overrun`.
  - Latch `cfg_en0`, `cfg_en1` and `cfg_prio1` into shadow registers.
  - All arbitration uses only the shadow values.
- Read request rules, in `S_RUN`:
  - `ram0_rd = region_0_active & en0_sh`. `ram1_rd` is defined the same way for region 1.
  - Each region that reads advances its own counter by 1, regardless of which region wins overlap, so each image scans linearly.
  - `ramN_addr` is the counter value before the increment.
- Counter wrap:
  - A read at address `IMGn_PIXELS-1` wraps the counter to 0.
  - A read issued while the counter is already wrapped (i.e. the counter has wrapped since the last `vs` edge) sets `overrun`.
- Winner selection, in the request cycle:
  - Only region 0 reads: region 0 wins.
  - Only region 1 reads: region 1 wins.
  - Both read: `prio1_sh` selects the winner.
  - Neither reads: no winner.
- The winner code is registered (`sel_d`).
- `img` is a combinational mux of `ram0_rdata` / `ram1_rdata` / blank, driven by `sel_d`.
- A `vs` edge and a region strobe in the same cycle: the counter clear takes precedence and the read uses address 0.

## Timing
- Reset values: `ram*_rd=0`, `ram*_addr=0`, `img=0`, `frame_start=0`, `overrun=0`, `sel_d`=none, shadows=0, FSM=`S_IDLE`.
- Latency: `region_n_active` high in cycle t means the address is valid in t, `ramN_rdata` is valid in t+1, and `img` is valid in t+1. The timing generator samples `img` at the end of t+1.
- `frame_start` is asserted in the cycle after `vs` is first seen high.
- Configuration writes between `vs` edges have no visible effect until the next edge.
- Reset mid-frame: all outputs return to their reset values immediately; output resumes only after the next `vs` rising edge.

## Configuration
- `HDMI_ARB_BG_EN`:
  - Defined: adds input `cfg_bg` (24 bits), shadowed at `vs` like the other configuration inputs. No-winner pixels and disabled-layer pixels output `bg_sh`.
  - Undefined: the port is absent and no-winner pixels are 0.
  - `S_IDLE` outputs 0 in both builds.

## Test plan
- Reset, then `vs` pulse, then region 0 only for 4 cycles with `ram0_rdata = addr` → `ram0_addr` 0,1,2,3; `img` = 0x000000, 0x000001, 0x000002, 0x000003 one cycle later; `ram1_rd` stays 0.
- Both regions active for 3 cycles with `cfg_prio1=1` → both counters advance to 3; `img` equals `ram1_rdata`; flip `cfg_prio1` mid-frame → no change until the next `vs` edge, after which `img` equals `ram0_rdata`.
- Set `cfg_en0=0` and latch it at `vs`; region 0 active → `ram0_rd=0`, counter stays 0, `img`=0, or `cfg_bg` when built with `HDMI_ARB_BG_EN`.
- `IMG0_PIXELS=4`; region 0 active for 6 cycles → addresses 0,1,2,3,0,1; `overrun` goes high at the fifth read and clears at the next `vs` rising edge.
- Assert `rst` mid-frame with region 0 active at address 100 → all outputs 0 at once; no reads until `vs`, after which addressing restarts at 0.
- `vs` rises in the same cycle as a region 1 strobe with its counter at 50 → `ram1_addr=0`, `frame_start` pulses once, next address is 1.

Source files
------------

// File: rtl/hdmi_layer_arbiter.sv
// hdmi_layer_arbiter: two-layer pixel fetch arbiter for the 720p HDMI path.
// Issues linear reads into two image buffers and returns the winning pixel
// one cycle later; layer config is shadowed and applied at each vs edge.
//
// Ports:
//   video_clk, rst        pixel clock, async active-high reset
//   vs                    field sync from timing generator
//   region_0/1_active     per-pixel region strobes
//   cfg_en0/1, cfg_prio1  CPU layer enables and overlap priority
//   cfg_bg                background colour (HDMI_ARB_BG_EN builds only)
//   ram0/1_rd, _addr      buffer read strobes and addresses
//   ram0/1_rdata          buffer read data, 1-cycle latency
//   img_r/g/b             selected pixel
//   frame_start           one-cycle pulse after each vs rise
//   overrun               sticky per-frame buffer overrun flag
//
// Option macro: HDMI_ARB_BG_EN adds cfg_bg and a background colour for
// pixels with no winner.

module hdmi_layer_arbiter #(
  parameter int IMG0_PIXELS = 65536,
  parameter int IMG1_PIXELS = 65536,
  parameter int ADDR_W      = 16
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic              vs,
  input  logic              region_0_active,
  input  logic              region_1_active,
  input  logic              cfg_en0,
  input  logic              cfg_en1,
  input  logic              cfg_prio1,
`ifdef HDMI_ARB_BG_EN
  input  logic [23:0]       cfg_bg,
`endif
  output logic              ram0_rd,
  output logic              ram1_rd,
  output logic [ADDR_W-1:0] ram0_addr,
  output logic [ADDR_W-1:0] ram1_addr,
  input  logic [23:0]       ram0_rdata,
  input  logic [23:0]       ram1_rdata,
  output logic [7:0]        img_r,
  output logic [7:0]        img_g,
  output logic [7:0]        img_b,
  output logic              frame_start,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST0 =
    ADDR_W'(IMG0_PIXELS - 1);
  localparam logic [ADDR_W-1:0] LAST1 =
    ADDR_W'(IMG1_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // SEL_OFF: idle/reset black, SEL_BG: running with no winner.
  typedef enum logic [1:0] {
    SEL_OFF,
    SEL_BG,
    SEL_L0,
    SEL_L1
  } sel_t;

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  logic              vs_q;
  logic              en0_sh_q, en1_sh_q, prio1_sh_q;
  logic [ADDR_W-1:0] cnt0_q, cnt0_d;
  logic [ADDR_W-1:0] cnt1_q, cnt1_d;
  logic              wrap0_q, wrap0_d;
  logic              wrap1_q, wrap1_d;
  logic              ovr_q, ovr_d;
  logic              fs_q;
`ifdef HDMI_ARB_BG_EN
  logic [23:0]       bg_sh_q;
`endif

  logic              vs_rise;
  logic              run_w;
  logic              en0_w, en1_w, prio1_w;
  logic [ADDR_W-1:0] base0, base1;
  logic              wb0, wb1;
  logic              rd0_w, rd1_w;
  logic [23:0]       pix;

  // The rise is taken against last cycle's vs so that a strobe in the
  // rising cycle already sees the cleared counters and new settings;
  // those settings are what the shadows capture at the end of the cycle.
  always_comb begin
    vs_rise = vs & ~vs_q & ~rst;
    run_w   = (state_q == S_RUN) | vs_rise;
    en0_w   = vs_rise ? cfg_en0 : en0_sh_q;
    en1_w   = vs_rise ? cfg_en1 : en1_sh_q;
    prio1_w = vs_rise ? cfg_prio1 : prio1_sh_q;
    base0   = vs_rise ? '0 : cnt0_q;
    base1   = vs_rise ? '0 : cnt1_q;
    wb0     = vs_rise ? 1'b0 : wrap0_q;
    wb1     = vs_rise ? 1'b0 : wrap1_q;
    rd0_w   = run_w & region_0_active & en0_w;
    rd1_w   = run_w & region_1_active & en1_w;

    cnt0_d  = base0;
    wrap0_d = wb0;
    if (rd0_w) begin
      if (base0 == LAST0) begin
        cnt0_d  = '0;
        wrap0_d = 1'b1;
      end else begin
        cnt0_d = base0 + ONE;
      end
    end

    cnt1_d  = base1;
    wrap1_d = wb1;
    if (rd1_w) begin
      if (base1 == LAST1) begin
        cnt1_d  = '0;
        wrap1_d = 1'b1;
      end else begin
        cnt1_d = base1 + ONE;
      end
    end

    // A read after the wrap means the region is larger than its buffer.
    ovr_d = (vs_rise ? 1'b0 : ovr_q)
          | (rd0_w & wb0)
          | (rd1_w & wb1);

    if (!run_w)
      sel_d = SEL_OFF;
    else if (rd0_w && rd1_w)
      sel_d = prio1_w ? SEL_L1 : SEL_L0;
    else if (rd0_w)
      sel_d = SEL_L0;
    else if (rd1_w)
      sel_d = SEL_L1;
    else
      sel_d = SEL_BG;

    state_d = vs_rise ? S_RUN : state_q;
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= SEL_OFF;
      vs_q       <= 1'b0;
      en0_sh_q   <= 1'b0;
      en1_sh_q   <= 1'b0;
      prio1_sh_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      wrap0_q    <= 1'b0;
      wrap1_q    <= 1'b0;
      ovr_q      <= 1'b0;
      fs_q       <= 1'b0;
`ifdef HDMI_ARB_BG_EN
      bg_sh_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vs_q    <= vs;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      wrap0_q <= wrap0_d;
      wrap1_q <= wrap1_d;
      ovr_q   <= ovr_d;
      fs_q    <= vs_rise;
      if (vs_rise) begin
        en0_sh_q   <= cfg_en0;
        en1_sh_q   <= cfg_en1;
        prio1_sh_q <= cfg_prio1;
`ifdef HDMI_ARB_BG_EN
        bg_sh_q    <= cfg_bg;
`endif
      end
    end
  end

  always_comb begin
    pix = '0;
    unique case (sel_q)
      SEL_L0:  pix = ram0_rdata;
      SEL_L1:  pix = ram1_rdata;
`ifdef HDMI_ARB_BG_EN
      SEL_BG:  pix = bg_sh_q;
`else
      SEL_BG:  pix = '0;
`endif
      default: pix = '0;
    endcase
  end

  assign ram0_rd     = rd0_w;
  assign ram1_rd     = rd1_w;
  assign ram0_addr   = base0;
  assign ram1_addr   = base1;
  assign img_r       = pix[23:16];
  assign img_g       = pix[15:8];
  assign img_b       = pix[7:0];
  assign frame_start = fs_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_hdmi_layer_arbiter.sv
// tb_hdmi_layer_arbiter: directed vectors with a scoreboard queue;
// the driver queues per-cycle expectations and a monitor checks them.

module tb_hdmi_layer_arbiter;

  localparam int AW = 16;
`ifdef HDMI_ARB_BG_EN
  localparam logic [23:0] B = 24'h123456;
`else
  localparam logic [23:0] B = 24'h000000;
`endif

  logic          video_clk = 1'b0;
  logic          rst = 1'b1;
  logic          vs = 1'b0;
  logic          r0 = 1'b0;
  logic          r1 = 1'b0;
  logic          en0 = 1'b1;
  logic          en1 = 1'b1;
  logic          prio1 = 1'b0;
  logic          ram0_rd, ram1_rd;
  logic [AW-1:0] ram0_addr, ram1_addr;
  logic [23:0]   ram0_rdata = '0;
  logic [23:0]   ram1_rdata = '0;
  logic [7:0]    img_r, img_g, img_b;
  logic          frame_start, overrun;
`ifdef HDMI_ARB_BG_EN
  logic [23:0]   cfg_bg = B;
`endif

  hdmi_layer_arbiter #(
    .IMG0_PIXELS(128),
    .IMG1_PIXELS(65536),
    .ADDR_W(AW)
  ) dut (
    .video_clk(video_clk),
    .rst(rst),
    .vs(vs),
    .region_0_active(r0),
    .region_1_active(r1),
    .cfg_en0(en0),
    .cfg_en1(en1),
    .cfg_prio1(prio1),
`ifdef HDMI_ARB_BG_EN
    .cfg_bg(cfg_bg),
`endif
    .ram0_rd(ram0_rd),
    .ram1_rd(ram1_rd),
    .ram0_addr(ram0_addr),
    .ram1_addr(ram1_addr),
    .ram0_rdata(ram0_rdata),
    .ram1_rdata(ram1_rdata),
    .img_r(img_r),
    .img_g(img_g),
    .img_b(img_b),
    .frame_start(frame_start),
    .overrun(overrun)
  );

  always #5 video_clk = ~video_clk;

  // Buffer model: buffer 0 holds its address, buffer 1 holds A0_0000+addr.
  always @(posedge video_clk) begin
    if (ram0_rd) ram0_rdata <= {8'h00, ram0_addr};
    if (ram1_rd) ram1_rdata <= {8'hA0, ram1_addr};
  end

  typedef struct {
    logic        rd0;
    logic        rd1;
    int          a0;
    int          a1;
    logic [23:0] img;
    logic        fs;
    logic        ovr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic chk(string nm, logic [23:0] act, logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge video_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        chk("ram0_rd", 24'(ram0_rd), 24'(e.rd0));
        chk("ram1_rd", 24'(ram1_rd), 24'(e.rd1));
        if (e.a0 >= 0)
          chk("ram0_addr", 24'(ram0_addr), 24'(e.a0));
        if (e.a1 >= 0)
          chk("ram1_addr", 24'(ram1_addr), 24'(e.a1));
        chk("img", {img_r, img_g, img_b}, e.img);
        chk("frame_start", 24'(frame_start), 24'(e.fs));
        chk("overrun", 24'(overrun), 24'(e.ovr));
      end
    end
  end

  task automatic step(
    input logic v, input logic s0, input logic s1,
    input logic rd0, input logic rd1,
    input int a0, input int a1,
    input logic [23:0] img,
    input logic fs, input logic ovr
  );
    exp_t e;
    vs = v;
    r0 = s0;
    r1 = s1;
    e.rd0 = rd0;
    e.rd1 = rd1;
    e.a0  = a0;
    e.a1  = a1;
    e.img = img;
    e.fs  = fs;
    e.ovr = ovr;
    q.push_back(e);
    @(posedge video_clk);
    #1;
  endtask

  initial begin
    @(posedge video_clk);
    #1;
    // Reset: strobes are ignored and everything reads zero.
    repeat (3) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Region 0 only, linear scan.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, B, 1, 0);
    step(0, 1, 0, 1, 0, 1, 0, 24'h000000, 0, 0);
    step(0, 1, 0, 1, 0, 2, 0, 24'h000001, 0, 0);
    step(0, 1, 0, 1, 0, 3, 0, 24'h000002, 0, 0);
    step(0, 0, 0, 0, 0, 4, 0, 24'h000003, 0, 0);

    // Overlap with region 1 priority; mid-frame flip is not seen.
    prio1 = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, B, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, B, 1, 0);
    prio1 = 1'b0;
    step(0, 1, 1, 1, 1, 1, 1, 24'hA00000, 0, 0);
    step(0, 1, 1, 1, 1, 2, 2, 24'hA00001, 0, 0);
    step(0, 0, 0, 0, 0, 3, 3, 24'hA00002, 0, 0);
    // Next frame picks up region 0 priority.
    step(1, 0, 0, 0, 0, 0, 0, B, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, B, 1, 0);
    step(0, 1, 1, 1, 1, 1, 1, 24'h000000, 0, 0);
    step(0, 0, 0, 0, 0, 2, 2, 24'h000001, 0, 0);

    // Layer 0 disabled at the frame edge.
    en0 = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, B, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, B, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, B, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, B, 0, 0);
    en0 = 1'b1;

    // Buffer 0 holds 128 pixels; 130 reads wrap and flag overrun.
    step(1, 0, 0, 0, 0, 0, -1, B, 0, 0);
    step(0, 1, 0, 1, 0, 0, -1, B, 1, 0);
    for (int i = 1; i <= 129; i++)
      step(0, 1, 0, 1, 0, i % 128, -1,
           24'((i - 1) % 128), 0, (i == 129));
    step(0, 0, 0, 0, 0, 2, -1, 24'h000001, 0, 1);
    step(1, 0, 0, 0, 0, 0, -1, B, 0, 1);
    step(0, 0, 0, 0, 0, 0, -1, B, 1, 0);

    // Reset mid-frame at address 100.
    for (int i = 0; i < 100; i++)
      step(0, 1, 0, 1, 0, i, -1,
           (i == 0) ? B : 24'(i - 1), 0, 0);
    rst = 1'b1;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0, 24'h000000, 1, 0);
    step(0, 0, 0, 0, 0, 2, 0, 24'h000001, 0, 0);

    // vs rises together with a region 1 strobe at address 50.
    for (int i = 0; i < 50; i++)
      step(0, 0, 1, 0, 1, 2, i,
           (i == 0) ? B : (24'hA00000 | 24'(i - 1)), 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 24'hA00031, 0, 0);
    step(0, 0, 1, 0, 1, 0, 1, 24'hA00000, 1, 0);
    step(0, 0, 0, 0, 0, 0, 2, 24'hA00001, 0, 0);

    for (int k = 0; k < 5 && q.size() > 0; k++)
      @(negedge video_clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
